lse_add_pipe: RTL and testbench

Pipelined, parametrised log-sum-exp adder: computes max(a,b) + f(|a−b|) in the signed fixed-point log domain, with the correction f taken from an internal, runtime-writable LUT. It supports a full-width mode and a packed multi-lane mode, where each lane is an independent LSE add. It uses valid/ready flow control and replaces the single-issue `lse_add` inside the PE accumulation datapath.

---
 rtl/lse_pkg.sv | 27 ++
 rtl/lse_lane.sv | 67 ++++++
 rtl/lse_add_pipe.sv | 187 ++++++++++++++++++
 tb/tb_lse_add_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lse_pkg.sv
// Shared types and constants for the pipelined log-sum-exp adder.
package lse_pkg;

  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_PACK = 2'b01,
    MODE_RSV2 = 2'b10,
    MODE_RSV3 = 2'b11
  } pe_mode_e;

  typedef struct packed {
    logic     valid;
    pe_mode_e mode;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_IDLE = '{valid: 1'b0, mode: MODE_FULL};

  // Most negative two's-complement code of a w-bit field; doubles as log(0).
  function automatic logic [63:0] neg_inf(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/lse_lane.sv
// One LSE slice of width W: compare/difference (S1 input), correction add (S2 input)
// and saturation (S3 input). Instantiated once at full width and once per packed lane.
module lse_lane
  import lse_pkg::*;
#(
  parameter int W             = 24,
  parameter int LUT_ADDR_BITS = 10,
  parameter int LUT_PRECISION = 10,
  parameter int IDX_SH        = 0,
  parameter int CORR_SH       = 0
) (
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  output logic [W-1:0]             f_max,
  output logic [W:0]               f_diff,
  output logic                     f_byp,
  output logic [W-1:0]             f_byp_val,
  input  logic [W-1:0]             s1_max,
  input  logic [W:0]               s1_diff,
  input  logic                     s1_byp,
  input  logic [W-1:0]             s1_byp_val,
  output logic [LUT_ADDR_BITS-1:0] lut_idx,
  input  logic [LUT_PRECISION-1:0] lut_rdata,
  output logic [W+1:0]             sum,
  input  logic [W+1:0]             s2_sum,
  output logic [W-1:0]             res,
  output logic                     sat
);

  localparam logic [W-1:0] NEG_INF = W'(neg_inf(W));
  localparam logic [W-1:0] MAX_POS = W'(max_pos(W));
  localparam int XW = (W + 1 > LUT_ADDR_BITS) ? W + 1 : LUT_ADDR_BITS;
  localparam int XC = (LUT_PRECISION > W) ? LUT_PRECISION : W;

  logic          a_gt_b;
  logic [W-1:0]  mn;
  logic [XW-1:0] idx_x;
  logic          idx_ok;
  logic [XC-1:0] corr_x;
  logic [W-1:0]  corr;

  always_comb begin
    a_gt_b    = $signed(a) > $signed(b);
    f_max     = a_gt_b ? a : b;
    mn        = a_gt_b ? b : a;
    f_diff    = {f_max[W-1], f_max} - {mn[W-1], mn};
    f_byp     = (a == NEG_INF) || (b == NEG_INF);
    f_byp_val = (a == NEG_INF) ? b : a;
  end

  // Sum is kept two bits wider than the lane so the correction can never wrap it.
  always_comb begin
    idx_x   = XW'(s1_diff) >> IDX_SH;
    idx_ok  = (idx_x >> LUT_ADDR_BITS) == '0;
    lut_idx = LUT_ADDR_BITS'(idx_x);
    corr_x  = XC'(lut_rdata) >> CORR_SH;
    corr    = idx_ok ? W'(corr_x) : '0;
    if (s1_byp) sum = {{2{s1_byp_val[W-1]}}, s1_byp_val};
    else        sum = {{2{s1_max[W-1]}}, s1_max} + {2'b00, corr};
  end

  always_comb begin
    sat = ~s2_sum[W+1] & (|s2_sum[W:W-1]);
    res = sat ? MAX_POS : s2_sum[W-1:0];
  end

endmodule

// File: rtl/lse_add_pipe.sv
// Three-stage log-sum-exp adder (full-width or packed lanes) with runtime-writable LUT.
// Define LSE_ADD_PIPE_SAT_CNT_EN to build the saturation event counter on sat_count.
module lse_add_pipe
  import lse_pkg::*;
#(
  parameter int WIDTH         = 24,
  parameter int SUB_WIDTH     = 6,
  parameter int LUT_ADDR_BITS = 10,
  parameter int LUT_PRECISION = 10,
  parameter int IDX_SHIFT     = 0,
  parameter int PACK_SHIFT    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         operand_a,
  input  logic [WIDTH-1:0]         operand_b,
  input  logic [1:0]               pe_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     out_sat,
  output logic                     out_err,
  input  logic                     lut_we,
  input  logic [LUT_ADDR_BITS-1:0] lut_addr,
  input  logic [LUT_PRECISION-1:0] lut_wdata,
  output logic [15:0]              sat_count
);

  localparam int LANES     = WIDTH / SUB_WIDTH;
  localparam int LUT_DEPTH = 1 << LUT_ADDR_BITS;
  localparam logic [WIDTH-1:0] NEG_INF_W = WIDTH'(neg_inf(WIDTH));

  logic       stall;
  stage_ctl_t s1_ctl, s2_ctl;

  logic [LUT_PRECISION-1:0] lut [LUT_DEPTH];

  logic [WIDTH-1:0]         f_max, s1_f_max, f_byp_val, s1_f_byp_val, f_res;
  logic [WIDTH:0]           f_diff, s1_f_diff;
  logic                     f_byp, s1_f_byp, f_sat;
  logic [LUT_ADDR_BITS-1:0] f_idx;
  logic [WIDTH+1:0]         f_sum, s2_f_sum;

  logic [SUB_WIDTH-1:0]     p_max [LANES];
  logic [SUB_WIDTH-1:0]     s1_p_max [LANES];
  logic [SUB_WIDTH:0]       p_diff [LANES];
  logic [SUB_WIDTH:0]       s1_p_diff [LANES];
  logic                     p_byp [LANES];
  logic                     s1_p_byp [LANES];
  logic [SUB_WIDTH-1:0]     p_byp_val [LANES];
  logic [SUB_WIDTH-1:0]     s1_p_byp_val [LANES];
  logic [LUT_ADDR_BITS-1:0] p_idx [LANES];
  logic [SUB_WIDTH+1:0]     p_sum [LANES];
  logic [SUB_WIDTH+1:0]     s2_p_sum [LANES];
  logic [SUB_WIDTH-1:0]     p_res [LANES];
  logic                     p_sat [LANES];

  logic [WIDTH-1:0] nxt_res;
  logic             nxt_sat, nxt_err;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Plain register array: a write lands at the clock edge, so a same-cycle S2 read sees old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_addr] <= lut_wdata;
    end
  end

  lse_lane #(
    .W(WIDTH), .LUT_ADDR_BITS(LUT_ADDR_BITS), .LUT_PRECISION(LUT_PRECISION),
    .IDX_SH(IDX_SHIFT), .CORR_SH(0)
  ) u_full (
    .a(operand_a), .b(operand_b),
    .f_max(f_max), .f_diff(f_diff), .f_byp(f_byp), .f_byp_val(f_byp_val),
    .s1_max(s1_f_max), .s1_diff(s1_f_diff), .s1_byp(s1_f_byp), .s1_byp_val(s1_f_byp_val),
    .lut_idx(f_idx), .lut_rdata(lut[f_idx]), .sum(f_sum),
    .s2_sum(s2_f_sum), .res(f_res), .sat(f_sat)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lse_lane #(
      .W(SUB_WIDTH), .LUT_ADDR_BITS(LUT_ADDR_BITS), .LUT_PRECISION(LUT_PRECISION),
      .IDX_SH(0), .CORR_SH(PACK_SHIFT)
    ) u_lane (
      .a(operand_a[l*SUB_WIDTH +: SUB_WIDTH]), .b(operand_b[l*SUB_WIDTH +: SUB_WIDTH]),
      .f_max(p_max[l]), .f_diff(p_diff[l]), .f_byp(p_byp[l]), .f_byp_val(p_byp_val[l]),
      .s1_max(s1_p_max[l]), .s1_diff(s1_p_diff[l]), .s1_byp(s1_p_byp[l]),
      .s1_byp_val(s1_p_byp_val[l]),
      .lut_idx(p_idx[l]), .lut_rdata(lut[p_idx[l]]), .sum(p_sum[l]),
      .s2_sum(s2_p_sum[l]), .res(p_res[l]), .sat(p_sat[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctl       <= CTL_IDLE;
      s2_ctl       <= CTL_IDLE;
      s1_f_max     <= '0;
      s1_f_diff    <= '0;
      s1_f_byp     <= 1'b0;
      s1_f_byp_val <= '0;
      s2_f_sum     <= '0;
      for (int l = 0; l < LANES; l++) begin
        s1_p_max[l]     <= '0;
        s1_p_diff[l]    <= '0;
        s1_p_byp[l]     <= 1'b0;
        s1_p_byp_val[l] <= '0;
        s2_p_sum[l]     <= '0;
      end
    end else if (!stall) begin
      s1_ctl.valid <= in_valid;
      s1_ctl.mode  <= pe_mode_e'(pe_mode);
      s1_f_max     <= f_max;
      s1_f_diff    <= f_diff;
      s1_f_byp     <= f_byp;
      s1_f_byp_val <= f_byp_val;
      s2_ctl       <= s1_ctl;
      s2_f_sum     <= f_sum;
      for (int l = 0; l < LANES; l++) begin
        s1_p_max[l]     <= p_max[l];
        s1_p_diff[l]    <= p_diff[l];
        s1_p_byp[l]     <= p_byp[l];
        s1_p_byp_val[l] <= p_byp_val[l];
        s2_p_sum[l]     <= p_sum[l];
      end
    end
  end

  always_comb begin
    nxt_res = '0;
    nxt_sat = 1'b0;
    nxt_err = 1'b0;
    case (s2_ctl.mode)
      MODE_FULL: begin
        nxt_res = f_res;
        nxt_sat = f_sat;
      end
      MODE_PACK: begin
        for (int l = 0; l < LANES; l++) begin
          nxt_res[l*SUB_WIDTH +: SUB_WIDTH] = p_res[l];
          nxt_sat = nxt_sat | p_sat[l];
        end
      end
      default: begin
        nxt_res = NEG_INF_W;
        nxt_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_ctl.valid;
      result    <= nxt_res;
      out_sat   <= nxt_sat;
      out_err   <= nxt_err;
    end
  end

`ifdef LSE_ADD_PIPE_SAT_CNT_EN
  logic [15:0] sat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  assign sat_count = sat_cnt;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_lse_add_pipe.sv
// Directed self-checking bench for lse_add_pipe with default parameters.
module tb_lse_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] operand_a = '0;
  logic [23:0] operand_b = '0;
  logic [1:0]  pe_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] result;
  logic        out_sat;
  logic        out_err;
  logic        lut_we = 1'b0;
  logic [9:0]  lut_addr = '0;
  logic [9:0]  lut_wdata = '0;
  logic [15:0] sat_count;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef LSE_ADD_PIPE_SAT_CNT_EN
  localparam int SAT_EN = 1;
`else
  localparam int SAT_EN = 0;
`endif

  always #5 clk = ~clk;

  lse_add_pipe #(
    .WIDTH(24), .SUB_WIDTH(6), .LUT_ADDR_BITS(10), .LUT_PRECISION(10),
    .IDX_SHIFT(0), .PACK_SHIFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .pe_mode(pe_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_sat(out_sat), .out_err(out_err),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .sat_count(sat_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_identity();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      lut_we    = 1'b1;
      lut_addr  = 10'(i);
      lut_wdata = 10'(i);
    end
    @(negedge clk);
    lut_we = 1'b0;
  endtask

  task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic [1:0] m);
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    pe_mode   = m;
    in_valid  = 1'b1;
  endtask

  task automatic wait_out(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(got), 1);
  endtask

  task automatic op_chk(input logic [23:0] a, input logic [23:0] b, input logic [1:0] m,
                        input string tag, input logic [23:0] er, input logic es,
                        input logic ee);
    issue(a, b, m);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(tag);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_sat"}, 32'(out_sat), 32'(es));
    chk({tag, "_err"}, 32'(out_err), 32'(ee));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] bp_exp [6];
    logic [23:0] rx [$];
    int issued;
    int stale;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_out_sat", 32'(out_sat), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_sat_count", 32'(sat_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    // Full-width basics and LUT range boundary
    load_identity();
    op_chk(24'h000010, 24'h000013, 2'b00, "full_small", 24'h000016, 1'b0, 1'b0);
    op_chk(24'h100000, 24'h200000, 2'b00, "full_big", 24'h200000, 1'b0, 1'b0);
    op_chk(24'hFFFFF0, 24'hFFFFFE, 2'b00, "full_neg", 24'h00000C, 1'b0, 1'b0);
    op_chk(24'h000000, 24'h0003FF, 2'b00, "idx_1023", 24'h0007FE, 1'b0, 1'b0);
    op_chk(24'h000000, 24'h000400, 2'b00, "idx_1024", 24'h000400, 1'b0, 1'b0);

    // NEG_INF operands
    load_identity();
    op_chk(24'h800000, 24'h123456, 2'b00, "ninf_a", 24'h123456, 1'b0, 1'b0);
    op_chk(24'h123456, 24'h800000, 2'b00, "ninf_b", 24'h123456, 1'b0, 1'b0);
    op_chk(24'h800000, 24'h800000, 2'b00, "ninf_ab", 24'h800000, 1'b0, 1'b0);

    // LUT write racing an S2 read, then saturation
    load_identity();
    issue(24'h7FFFFF, 24'h7FFFFF, 2'b00);
    @(negedge clk);
    in_valid  = 1'b0;
    lut_we    = 1'b1;
    lut_addr  = 10'd0;
    lut_wdata = 10'd5;
    @(negedge clk);
    lut_we = 1'b0;
    wait_out("sat_old");
    chk("sat_old_result", 32'(result), 'h7FFFFF);
    chk("sat_old_sat", 32'(out_sat), 0);
    op_chk(24'h7FFFFF, 24'h7FFFFF, 2'b00, "sat_new", 24'h7FFFFF, 1'b1, 1'b0);
    @(negedge clk);
    chk("sat_count_1", 32'(sat_count), 32'(SAT_EN));

    // Packed lanes and reserved modes
    load_identity();
    op_chk(24'h041041, 24'h0C30C3, 2'b01, "pack", 24'h145145, 1'b0, 1'b0);
    op_chk(24'h800000, 24'h0C30C3, 2'b01, "pack_ninf", 24'h0C6186, 1'b0, 1'b0);
    op_chk(24'h7DF7DF, 24'h79E79E, 2'b01, "pack_sat", 24'h7DF7DF, 1'b1, 1'b0);
    @(negedge clk);
    chk("sat_count_2", 32'(sat_count), 32'(2 * SAT_EN));
    op_chk(24'h123456, 24'h000001, 2'b10, "rsv2", 24'h800000, 1'b0, 1'b1);
    op_chk(24'h000010, 24'h000013, 2'b11, "rsv3", 24'h800000, 1'b0, 1'b1);

    // Backpressure: out_ready low for cycles 4..8
    load_identity();
    bp_exp = '{24'h000102, 24'h000204, 24'h000306, 24'h000408, 24'h00050A, 24'h00060C};
    issued = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 8);
      #1;
      if (c == 4) begin
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_out_valid_stall", 32'(out_valid), 1);
      end
      if (c >= 5 && c <= 8) chk("bp_hold_result", 32'(result), 'h000102);
      if (c == 9) chk("bp_in_ready_high", 32'(in_ready), 1);
      if (out_valid && out_ready) rx.push_back(result);
      if (in_ready && issued < 6) begin
        operand_a = 24'(256 * (issued + 1));
        operand_b = 24'(257 * (issued + 1));
        pe_mode   = 2'b00;
        in_valid  = 1'b1;
        issued++;
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    chk("bp_count", 32'(rx.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rx.size()) chk($sformatf("bp_order_%0d", i), 32'(rx[i]), 32'(bp_exp[i]));
    end

    // Reset with three operations in flight
    load_identity();
    issue(24'h000001, 24'h000002, 2'b00);
    issue(24'h000003, 24'h000004, 2'b00);
    issue(24'h000005, 24'h000006, 2'b00);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("midrst_no_stale", 32'(stale), 0);
    issue(24'h000010, 24'h000013, 2'b00);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_edge1", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_edge2", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_edge3", 32'(out_valid), 1);
    chk("midrst_result", 32'(result), 'h000013);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
